// File: rtl/mandel_pkg.sv
// mandel_pkg: shared widths, Q4.12 coordinate type and generator states
package mandel_pkg;
  localparam int CW = 16;
  localparam int FRAC = 12;
  localparam int NW = 8;
  localparam logic signed [CW-1:0] ONE_Q = 16'sh1000;
  typedef logic signed [CW-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} gen_state_t;
endpackage

// File: rtl/mandel_axis_step.sv
// mandel_axis_step: raster axis counter with a wrapping coordinate accumulator reloaded from its latched base
module mandel_axis_step #(
  parameter int N = 4,
  parameter int W = 16,
  localparam int AW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic signed [W-1:0] base,
  input  logic signed [W-1:0] delta,
  output logic [AW-1:0]       cnt,
  output logic signed [W-1:0] acc,
  output logic                wrap
);
  logic signed [W-1:0] base_q, delta_q;
  logic at_max;
  assign at_max = cnt == AW'(N - 1);
  assign wrap = step & at_max;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      base_q <= '0;
      delta_q <= '0;
    end else if (load) begin
      cnt <= '0;
      acc <= base;
      base_q <= base;
      delta_q <= delta;
    end else if (step) begin
      cnt <= at_max ? '0 : cnt + 1'b1;
      acc <= at_max ? base_q : acc + delta_q;
    end
  end
endmodule

// File: rtl/mandel_coord_gen.sv
// mandel_coord_gen: raster-scan seed generator feeding the mandelbrot iteration pipeline.
// Define MANDEL_COORD_ABORT_EN to add the i_abort frame-abort input.
module mandel_coord_gen
  import mandel_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CW = mandel_pkg::CW,
  parameter int NW = mandel_pkg::NW,
  localparam int XW = $clog2(H_RES),
  localparam int YW = $clog2(V_RES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
`ifdef MANDEL_COORD_ABORT_EN
  input  logic                 i_abort,
`endif
  input  logic signed [CW-1:0] i_cx0,
  input  logic signed [CW-1:0] i_cy0,
  input  logic signed [CW-1:0] i_dcx,
  input  logic signed [CW-1:0] i_dcy,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic signed [CW-1:0] o_x,
  output logic signed [CW-1:0] o_y,
  output logic signed [CW-1:0] o_cx,
  output logic signed [CW-1:0] o_cy,
  output logic [NW-1:0]        o_cnt,
  output logic [XW-1:0]        o_col,
  output logic [YW-1:0]        o_row,
  output logic                 o_sof,
  output logic                 o_eol,
  output logic                 o_busy,
  output logic                 o_done
);
  gen_state_t state;
  logic xfer, abort, load, step, col_wrap, last;
  assign o_x = '0;
  assign o_y = '0;
  assign o_cnt = '0;
  assign xfer = o_valid & i_ready;
`ifdef MANDEL_COORD_ABORT_EN
  assign abort = i_abort & (state != IDLE);
`else
  assign abort = 1'b0;
`endif
  assign load = (state == IDLE) & i_start;
  assign step = xfer & ~abort;
  mandel_axis_step #(.N(H_RES), .W(CW)) u_col (
    .clk(i_clk), .rst(i_rst), .load(load), .step(step),
    .base(i_cx0), .delta(i_dcx), .cnt(o_col), .acc(o_cx), .wrap(col_wrap)
  );
  // a column wrap advances the row; a row wrap marks the last pixel of the frame
  mandel_axis_step #(.N(V_RES), .W(CW)) u_row (
    .clk(i_clk), .rst(i_rst), .load(load), .step(col_wrap),
    .base(i_cy0), .delta(i_dcy), .cnt(o_row), .acc(o_cy), .wrap(last)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst || abort) begin
      state <= IDLE;
      o_valid <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_sof <= 1'b0;
      o_eol <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          state <= RUN;
          o_valid <= 1'b1;
          o_busy <= 1'b1;
          o_sof <= 1'b1;
          o_eol <= 1'b0;
        end
        RUN: if (xfer) begin
          o_sof <= 1'b0;
          o_eol <= o_col == XW'(H_RES - 2);
          if (last) begin
            state <= DONE;
            o_valid <= 1'b0;
            o_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mandel_coord_gen.sv
// tb_mandel_coord_gen: scoreboard bench for the raster seed generator on a 4x3 frame
module tb_mandel_coord_gen;
  localparam int H = 4, V = 3;
  logic clk = 0, rst = 1, start = 0, ready = 0, abort = 0;
  logic [15:0] cx0 = 0, cy0 = 0, dcx = 0, dcy = 0;
  logic valid, sof, eol, busy, done;
  logic [15:0] x, y, cx, cy;
  logic [7:0] cnt;
  logic [1:0] col, row;
  typedef struct packed {logic [15:0] cx, cy; logic [1:0] col, row; logic sof, eol;} seed_t;
  seed_t exp_q[$];
  seed_t cur, prev_out, e;
  int checks = 0, errors = 0, xfers = 0, dones = 0;
  bit prev_stall = 0, last_xfer = 0;
  assign cur = {cx, cy, col, row, sof, eol};
  always #5 clk = ~clk;

  mandel_coord_gen #(.H_RES(H), .V_RES(V)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
`ifdef MANDEL_COORD_ABORT_EN
    .i_abort(abort),
`endif
    .i_cx0(cx0), .i_cy0(cy0), .i_dcx(dcx), .i_dcy(dcy), .i_ready(ready),
    .o_valid(valid), .o_x(x), .o_y(y), .o_cx(cx), .o_cy(cy), .o_cnt(cnt),
    .o_col(col), .o_row(row), .o_sof(sof), .o_eol(eol), .o_busy(busy), .o_done(done)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // reference frame: pixel (c, r) has c = (cx0 + c*dcx, cy0 + r*dcy) mod 2^16
  task automatic push_frame(logic [15:0] a, b, da, db);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        exp_q.push_back('{16'(a + c * da), 16'(b + r * db), 2'(c), 2'(r), r == 0 && c == 0, c == H - 1});
  endtask

  always @(negedge clk) begin
    if (prev_stall) chk("stall_hold", {valid, cur}, {1'b1, prev_out});
    prev_stall = valid && !ready && !rst && !abort;
    prev_out = cur;
    if (done) begin
      dones++;
      chk("done_timing", {last_xfer, valid, exp_q.size() == 0}, 3'b101);
    end
    last_xfer = 0;
    if (valid && ready && !rst && !abort) begin
      xfers++;
      last_xfer = 1;
      if (exp_q.size() == 0) chk("extra_seed", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("seed", cur, e);
        chk("zero_seed", {x, y, cnt}, 0);
      end
    end
  end

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1 rst = 0;
    exp_q.delete();
  endtask

  task automatic start_frame(logic [15:0] a, b, da, db);
    push_frame(a, b, da, db);
    cx0 = a; cy0 = b; dcx = da; dcy = db; start = 1;
    @(posedge clk); #1 start = 0;
    cx0 = 16'($urandom); cy0 = 16'($urandom); dcx = 16'($urandom); dcy = 16'($urandom);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_frame(int mode, bit mid_start);
    int d0 = dones, n = 0;
    while (dones == d0 && n < 500) begin
      ready = mode == 0 ? 1'b1 : mode == 1 ? (n % 4 == 0 || n % 4 == 3) : 1'($urandom);
      start = mid_start && n == 3;
      if (start) cx0 = 16'h0000;
      @(posedge clk); #1 n++;
    end
    start = 0; ready = 0;
    chk("frame_done", dones - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1 chk("idle_after_done", {busy, valid, done}, 0);
    if (dones == d0) do_reset();
    exp_q.delete();
  endtask

  initial begin
    int x0, d0, n;
    repeat (3) @(posedge clk);
    #1 chk("rst_ctrl", {valid, busy, done, sof, eol}, 0);
    chk("rst_coord", {cx, cy, col, row}, 0);
    chk("rst_zero", {x, y, cnt}, 0);
    rst = 0;
    @(posedge clk); #1 chk("idle_no_start", {valid, busy}, 0);
    start_frame(16'hE000, 16'h1000, 16'h0400, 16'hFC00);
    run_frame(0, 0);
    start_frame(16'hE000, 16'h1000, 16'h0400, 16'hFC00);
    run_frame(1, 0);
    start_frame(16'hE000, 16'h1000, 16'h0400, 16'hFC00);
    run_frame(2, 1);
    start_frame(16'h0000, 16'h1000, 16'h0400, 16'hFC00);
    run_frame(0, 0);
    start_frame(16'h7000, 16'h0000, 16'h2000, 16'h0000);
    run_frame(0, 0);
    // reset after five transfers
    start_frame(16'hE000, 16'h1000, 16'h0400, 16'hFC00);
    x0 = xfers; d0 = dones; n = 0; ready = 1;
    while (xfers - x0 < 5 && n < 50) begin @(posedge clk); #1 n++; end
    chk("xfers_before_rst", xfers - x0, 5);
    rst = 1;
    @(posedge clk); #1 rst = 0; ready = 0;
    chk("rst_midframe", {valid, busy}, 0);
    exp_q.delete();
    repeat (20) @(posedge clk);
    #1 chk("no_done_after_rst", dones - d0, 0);
    start_frame(16'h1234, 16'h4321, 16'h0010, 16'hFFF0);
    run_frame(0, 0);
`ifdef MANDEL_COORD_ABORT_EN
    start_frame(16'hE000, 16'h1000, 16'h0400, 16'hFC00);
    x0 = xfers; d0 = dones; n = 0; ready = 1;
    while (xfers - x0 < 5 && n < 50) begin @(posedge clk); #1 n++; end
    abort = 1;
    @(posedge clk); #1 abort = 0;
    chk("abort_idle", {valid, busy}, 0);
    repeat (20) @(posedge clk);
    #1 chk("abort_no_done", dones - d0, 0);
    chk("abort_xfers", xfers - x0, 5);
    ready = 0;
    exp_q.delete();
`endif
    for (int i = 0; i < 4; i++) begin
      start_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      run_frame(2, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mandel_coord_gen.md
Name: mandel_coord_gen

Overview:
- Raster-scan seed generator directly upstream of the mandelbrot iteration pipeline.
- On a start pulse, sweeps H_RES x V_RES pixels and emits one pipeline seed per accepted transfer: z = 0, c = (cx, cy), count = 0, plus pixel position and frame markers.
- Coordinates are signed Q4.12: 1 sign bit, 3 integer bits, 12 fractional bits, so 0x1000 = 1.0 and 0x4000 = 4.0.

Parameters:
- H_RES, 640, pixels per line (>= 2).
- V_RES, 480, lines per frame (>= 2).
- CW, 16, coordinate width in bits (Q4.12 at 16).
- NW, 8, iteration-count width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  frame start pulse; honoured only in IDLE.
- i_cx0  in  CW  real part of the top-left pixel, latched at start.
- i_cy0  in  CW  imaginary part of the top-left pixel, latched at start.
- i_dcx  in  CW  signed real step per column, latched at start.
- i_dcy  in  CW  signed imaginary step per row, latched at start.
- i_ready  in  1  downstream can accept a seed.
- o_valid  out  1  seed available.
- o_x  out  CW  z real seed, always 0.
- o_y  out  CW  z imaginary seed, always 0.
- o_cx  out  CW  c real for the current pixel.
- o_cy  out  CW  c imaginary for the current pixel.
- o_cnt  out  NW  iteration count seed, always 0.
- o_col  out  clog2(H_RES)  column of the current pixel.
- o_row  out  clog2(V_RES)  row of the current pixel.
- o_sof  out  1  start of frame; high with pixel (0,0).
- o_eol  out  1  end of line; high when col = H_RES-1.
- o_busy  out  1  high in RUN and DONE.
- o_done  out  1  one-cycle pulse after the last pixel transfers.

Behaviour:
- Clocking and reset: one clock, i_clk. i_rst is synchronous and active-high. All outputs are registered.
- Reset values: state = IDLE. o_valid, o_busy, o_done, o_sof and o_eol are 0. o_cx, o_cy, o_col and o_row are 0. o_x, o_y and o_cnt are constant 0.
- States: IDLE, RUN, DONE.
- IDLE: when i_start = 1 at edge N:
  - latch cx0, cy0, dcx, dcy;
  - load col = 0, row = 0, cx = cx0, cy = cy0;
  - enter RUN. o_valid and o_sof are 1 after edge N, i.e. one cycle of latency.
- RUN handshake: a transfer occurs when o_valid & i_ready.
  - While o_valid = 1 and i_ready = 0, every output is held stable.
  - o_valid never drops in RUN except through reset.
  - One transfer per cycle maximum; back-to-back transfers are supported with no bubbles.
- Advance on each transfer:
  - If col < H_RES-1: col += 1, cx += dcx.
  - Otherwise: col = 0, cx = cx0, row += 1, cy += dcy.
  - o_sof is high only at (0,0). o_eol = (col == H_RES-1).
- Last pixel: a transfer at (H_RES-1, V_RES-1) moves the block to DONE. o_valid = 0 and o_done = 1 for exactly one cycle, then the block enters IDLE with o_busy = 0.
- Arithmetic: two's-complement add at CW bits, wrapping modulo 2^CW with no saturation. cx is reloaded from the latched cx0 at each line start, never accumulated across lines. Example: 0x7000 + 0x2000 = 0x9000.
- i_start is ignored in RUN and DONE. An i_start in the same cycle as o_done is ignored. Changes to i_cx0, i_cy0, i_dcx and i_dcy after start have no effect until the next start.
- Reset mid-frame: after the edge at which i_rst is sampled high, the block is in IDLE with reset values. Any held seed is discarded; no o_done.
- i_rst has priority over i_start in the same cycle.

Optional Feature:
- Macro: MANDEL_COORD_ABORT_EN.
- With the macro defined: an input port i_abort (1 bit) is added.
  - i_abort = 1 in RUN or DONE forces IDLE at the next edge with o_valid = 0, o_busy = 0 and no o_done pulse.
  - i_abort in IDLE has no effect; abort has priority over a simultaneous transfer.
- Without the macro: no i_abort port; a frame always runs to completion unless reset.

Decomposition:
- Package mandel_pkg holds:
  - localparams CW = 16, FRAC = 12, NW = 8, and ONE_Q = 16'sh1000;
  - typedef coord_t as a signed CW-bit type;
  - enum gen_state_t {IDLE, RUN, DONE}.
- Sub-module mandel_axis_step: counter plus coordinate accumulator, with inputs load, step, wrap-at-max and base/delta, and a wrap output. It is instantiated once for columns/cx and once for rows/cy; the column wrap drives the row step.

Test Plan:
- H_RES = 4, V_RES = 3, cx0 = 0xE000 (-2.0), cy0 = 0x1000, dcx = 0x0400, dcy = 0xFC00, i_ready = 1, one start pulse:
  - 12 consecutive transfers; cx per line is E000, E400, E800, EC00; cy per row is 1000, 0C00, 0800;
  - o_sof only on the first, o_eol on every 4th;
  - o_done one cycle after the 12th transfer.
- Same frame with i_ready toggled 1,0,0,1 repeatedly: outputs are stable while stalled, the sequence is identical to the previous case, and there are exactly 12 transfers.
- i_start pulsed again mid-frame with cx0 = 0x0000: ignored. The frame completes with the original values; a second start after o_done uses 0x0000.
- cx0 = 0x7000, dcx = 0x2000, H_RES = 4: the column sequence wraps to 7000, 9000, B000, D000.
- i_rst asserted after 5 transfers: o_valid = 0 and o_busy = 0 the next cycle, and no o_done. A fresh start restarts at (0,0) with o_sof = 1.
- With MANDEL_COORD_ABORT_EN: i_abort during transfer 6 leaves the block IDLE with no o_done and no 7th seed. Without the macro, the port is absent and elaboration is clean.
